// File: rtl/mic_pkg.sv
// MIC datapath shared definitions: B-bus sources,
// C-bus enable bit positions and shifter encodings.
package mic_pkg;

  typedef enum logic [3:0] {
    B_MDR  = 4'd0,
    B_PC   = 4'd1,
    B_MBR  = 4'd2,
    B_MBRU = 4'd3,
    B_SP   = 4'd4,
    B_LV   = 4'd5,
    B_CPP  = 4'd6,
    B_TOS  = 4'd7,
    B_OPC  = 4'd8
  } bsel_e;

  localparam int C_MAR = 0;
  localparam int C_MDR = 1;
  localparam int C_PC  = 2;
  localparam int C_SP  = 3;
  localparam int C_LV  = 4;
  localparam int C_CPP = 5;
  localparam int C_TOS = 6;
  localparam int C_OPC = 7;
  localparam int C_H   = 8;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SRA1 = 2'b01;
  localparam logic [1:0] SH_SLL8 = 2'b10;

endpackage

// File: rtl/mic_shifter.sv
// MIC shifter: pass, arithmetic right by 1, or left by 8.
// The unused 2'b11 code passes the input unchanged.
module mic_shifter
  import mic_pkg::*;
(
  input  logic [31:0] r,
  input  logic [1:0]  shift,
  output logic [31:0] c
);

  always_comb begin
    c = r;
    case (shift)
      SH_SRA1: c = {r[31], r[31:1]};
      SH_SLL8: c = {r[23:0], 8'h00};
      default: c = r;
    endcase
  end

endmodule

// File: rtl/mic_cbus_regfile.sv
// MIC write-back stage: shifter, C-bus register bank,
// N/Z flags, B-bus source mux, H and memory loads.
module mic_cbus_regfile
  import mic_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0,
  parameter logic [31:0] SP_RESET  = 32'h0,
  parameter logic [31:0] LV_RESET  = 32'h0,
  parameter logic [31:0] CPP_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        step,
  input  logic [31:0] alu_r,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic [1:0]  shift,
  input  logic [8:0]  c_en,
  input  logic [3:0]  b_sel,
  input  logic [31:0] mem_rd_data,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_fetch_data,
  input  logic        mem_fetch_valid,
  output logic [31:0] a_bus,
  output logic [31:0] b_bus,
  output logic        n_flag,
  output logic        z_flag,
  output logic [31:0] mar,
  output logic [31:0] mdr,
  output logic [31:0] pc
);

  logic [31:0] c_bus;
  logic [31:0] h_q, opc_q, tos_q, cpp_q;
  logic [31:0] lv_q, sp_q, pc_q, mdr_q, mar_q;
  logic [7:0]  mbr_q;
  logic [8:0]  we;

  mic_shifter u_shifter (
    .r     (alu_r),
    .shift (shift),
    .c     (c_bus)
  );

  assign we = step ? c_en : 9'h0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q   <= '0;
      opc_q <= '0;
      tos_q <= '0;
      cpp_q <= CPP_RESET;
      lv_q  <= LV_RESET;
      sp_q  <= SP_RESET;
      pc_q  <= PC_RESET;
      mar_q <= '0;
    end else begin
      if (we[C_H])   h_q   <= c_bus;
      if (we[C_OPC]) opc_q <= c_bus;
      if (we[C_TOS]) tos_q <= c_bus;
      if (we[C_CPP]) cpp_q <= c_bus;
      if (we[C_LV])  lv_q  <= c_bus;
      if (we[C_SP])  sp_q  <= c_bus;
      if (we[C_PC])  pc_q  <= c_bus;
      if (we[C_MAR]) mar_q <= c_bus;
    end
  end

  // Memory read data outranks a same-cycle C-bus write to MDR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mdr_q <= '0;
    end else if (step && mem_rd_valid) begin
      mdr_q <= mem_rd_data;
    end else if (we[C_MDR]) begin
      mdr_q <= c_bus;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mbr_q <= '0;
    end else if (step && mem_fetch_valid) begin
      mbr_q <= mem_fetch_data;
    end
  end

  // Z resets high to match R=0 while the datapath is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_flag <= 1'b0;
      z_flag <= 1'b1;
    end else if (step) begin
      n_flag <= alu_n;
      z_flag <= alu_z;
    end
  end

  always_comb begin
    b_bus = '0;
    case (bsel_e'(b_sel))
      B_MDR:   b_bus = mdr_q;
      B_PC:    b_bus = pc_q;
      B_MBR:   b_bus = {{24{mbr_q[7]}}, mbr_q};
      B_MBRU:  b_bus = {24'h0, mbr_q};
      B_SP:    b_bus = sp_q;
      B_LV:    b_bus = lv_q;
      B_CPP:   b_bus = cpp_q;
      B_TOS:   b_bus = tos_q;
      B_OPC:   b_bus = opc_q;
      default: b_bus = '0;
    endcase
  end

  assign a_bus = h_q;
  assign mar   = mar_q;
  assign mdr   = mdr_q;
  assign pc    = pc_q;

endmodule

// File: tb/tb_mic_cbus_regfile.sv
// Scoreboard bench for mic_cbus_regfile: stimulus queues
// expected values, a monitor pops and compares on demand.
module tb_mic_cbus_regfile;
  import mic_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        step;
  logic [31:0] alu_r;
  logic        alu_n, alu_z;
  logic [1:0]  shift;
  logic [8:0]  c_en;
  logic [3:0]  b_sel;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic [7:0]  mem_fetch_data;
  logic        mem_fetch_valid;
  logic [31:0] a_bus, b_bus, mar, mdr, pc;
  logic        n_flag, z_flag;

  mic_cbus_regfile #(
    .PC_RESET  (32'h100),
    .SP_RESET  (32'h8000),
    .LV_RESET  (32'h0),
    .CPP_RESET (32'h0)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .step            (step),
    .alu_r           (alu_r),
    .alu_n           (alu_n),
    .alu_z           (alu_z),
    .shift           (shift),
    .c_en            (c_en),
    .b_sel           (b_sel),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_valid    (mem_rd_valid),
    .mem_fetch_data  (mem_fetch_data),
    .mem_fetch_valid (mem_fetch_valid),
    .a_bus           (a_bus),
    .b_bus           (b_bus),
    .n_flag          (n_flag),
    .z_flag          (z_flag),
    .mar             (mar),
    .mdr             (mdr),
    .pc              (pc)
  );

  always #5 clk = ~clk;

  typedef enum int {K_B, K_A, K_PC, K_MDR, K_MAR, K_N, K_Z} kind_e;

  typedef struct {
    string       name;
    kind_e       kind;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [31:0] observe(kind_e k);
    case (k)
      K_B:     return b_bus;
      K_A:     return a_bus;
      K_PC:    return pc;
      K_MDR:   return mdr;
      K_MAR:   return mar;
      K_N:     return {31'h0, n_flag};
      default: return {31'h0, z_flag};
    endcase
  endfunction

  initial begin
    exp_t e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = observe(e.kind);
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic expect_val(string n, kind_e k, logic [31:0] v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic expect_b(string n, logic [3:0] s, logic [31:0] v);
    b_sel = s;
    #1;
    expect_val(n, K_B, v);
    -> chk_ev;
    #1;
  endtask

  task automatic fire();
    #1;
    -> chk_ev;
    #1;
  endtask

  // One enabled edge with the given C-bus request, then idle.
  task automatic wr(logic [8:0] en, logic [31:0] r, logic [1:0] sh,
                    logic n, logic z);
    c_en  = en;
    alu_r = r;
    shift = sh;
    alu_n = n;
    alu_z = z;
    step  = 1'b1;
    @(posedge clk);
    #1;
    step         = 1'b0;
    c_en         = '0;
    mem_rd_valid = 1'b0;
    mem_fetch_valid = 1'b0;
  endtask

  localparam logic [8:0] EN_TOS = 9'h1 << C_TOS;

  initial begin
    reset = 1'b0;
    step = 1'b0;
    alu_r = '0;
    alu_n = 1'b0;
    alu_z = 1'b1;
    shift = SH_NONE;
    c_en = '0;
    b_sel = '0;
    mem_rd_data = '0;
    mem_rd_valid = 1'b0;
    mem_fetch_data = '0;
    mem_fetch_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    #2;

    expect_val("rst_pc", K_PC, 32'h100);
    expect_val("rst_z", K_Z, 32'h1);
    expect_val("rst_n", K_N, 32'h0);
    expect_val("rst_a", K_A, 32'h0);
    fire();
    expect_b("rst_sp", 4'd4, 32'h8000);

    wr(EN_TOS, 32'h8000_0F00, SH_SRA1, 1'b1, 1'b0);
    expect_b("sra1", 4'd7, 32'hC000_0780);
    expect_val("flag_n_alu", K_N, 32'h1);
    expect_val("flag_z_alu", K_Z, 32'h0);
    fire();
    wr(EN_TOS, 32'h8000_0F00, SH_SLL8, 1'b1, 1'b0);
    expect_b("sll8", 4'd7, 32'h000F_0000);
    wr(EN_TOS, 32'h8000_0F00, 2'b11, 1'b1, 1'b0);
    expect_b("sh11", 4'd7, 32'h8000_0F00);
    wr(EN_TOS, 32'h0000_1234, SH_NONE, 1'b0, 1'b0);
    expect_b("pass", 4'd7, 32'h0000_1234);

    wr((9'h1 << C_H) | (9'h1 << C_SP) | (9'h1 << C_LV),
       32'h1234_5678, SH_NONE, 1'b0, 1'b0);
    expect_val("h_set", K_A, 32'h1234_5678);
    fire();
    expect_b("sp_set", 4'd4, 32'h1234_5678);
    wr((9'h1 << C_H) | (9'h1 << C_SP) | (9'h1 << C_LV),
       32'h0, SH_NONE, 1'b0, 1'b1);
    expect_val("h_zero", K_A, 32'h0);
    expect_val("z_set", K_Z, 32'h1);
    fire();
    expect_b("sp_zero", 4'd4, 32'h0);
    expect_b("lv_zero", 4'd5, 32'h0);

    c_en = 9'h1FF;
    alu_r = 32'hFFFF_FFFF;
    alu_n = 1'b1;
    alu_z = 1'b0;
    mem_rd_valid = 1'b1;
    mem_rd_data = 32'h1111_1111;
    mem_fetch_valid = 1'b1;
    mem_fetch_data = 8'h7E;
    repeat (2) @(posedge clk);
    #1;
    expect_val("hold_z", K_Z, 32'h1);
    expect_val("hold_n", K_N, 32'h0);
    expect_val("hold_a", K_A, 32'h0);
    expect_val("hold_pc", K_PC, 32'h100);
    expect_val("hold_mdr", K_MDR, 32'h0);
    fire();
    expect_b("hold_mbru", 4'd3, 32'h0);
    c_en = '0;
    mem_rd_valid = 1'b0;
    mem_fetch_valid = 1'b0;

    wr((9'h1 << C_MAR) | (9'h1 << C_PC), 32'h40, SH_NONE, 1'b0, 1'b0);
    expect_val("mar_wr", K_MAR, 32'h40);
    expect_val("pc_wr", K_PC, 32'h40);
    fire();

    mem_fetch_valid = 1'b1;
    mem_fetch_data = 8'hF3;
    wr('0, 32'h0, SH_NONE, 1'b0, 1'b1);
    expect_b("mbr_sext", 4'd2, 32'hFFFF_FFF3);
    expect_b("mbr_zext", 4'd3, 32'h0000_00F3);

    mem_rd_valid = 1'b1;
    mem_rd_data = 32'hDEAD_BEEF;
    wr(9'h1 << C_MDR, 32'h5, SH_NONE, 1'b0, 1'b0);
    expect_val("mdr_coll", K_MDR, 32'hDEAD_BEEF);
    fire();
    expect_b("mdr_bsel", 4'd0, 32'hDEAD_BEEF);
    wr(9'h1 << C_MDR, 32'h5, SH_NONE, 1'b0, 1'b0);
    expect_val("mdr_cbus", K_MDR, 32'h5);
    fire();

    wr((9'h1 << C_CPP) | (9'h1 << C_OPC), 32'h77, SH_NONE, 1'b0, 1'b0);
    expect_b("cpp", 4'd6, 32'h77);
    expect_b("opc", 4'd8, 32'h77);
    expect_b("bsel_hi", 4'd12, 32'h0);

    c_en = 9'h1 << C_PC;
    alu_r = 32'hABC;
    step = 1'b1;
    #2 reset = 1'b0;
    expect_val("async_pc", K_PC, 32'h100);
    fire();
    @(posedge clk);
    #2;
    step = 1'b0;
    c_en = '0;
    reset = 1'b1;
    expect_val("rst_hold_pc", K_PC, 32'h100);
    expect_val("rst_mdr", K_MDR, 32'h0);
    expect_val("rst_z2", K_Z, 32'h1);
    fire();

    #5;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard: got %0d left want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
